// File: rtl/art_pkg.sv
// art_pkg: shared widths and switch VN-valid encodings for the augmented reduction tree.
package art_pkg;
  localparam int ART_DATA_W = 32;
  typedef enum logic [1:0] {
    VN_VALID_NONE = 2'b00,
    VN_VALID_LO   = 2'b01,
    VN_VALID_HI   = 2'b10,
    VN_VALID_BOTH = 2'b11
  } vn_valid_e;
endpackage

// File: rtl/vn_lane_fifo.sv
// vn_lane_fifo: register-based lane FIFO; a push into a full FIFO succeeds when popped the same cycle.
module vn_lane_fifo
  import art_pkg::*;
#(
  parameter int DATA_TYPE  = ART_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic [DATA_TYPE-1:0] i_data,
  input  logic                 i_pop,
  output logic [DATA_TYPE-1:0] o_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [PTR_W:0]       o_count,
  output logic                 o_drop
);
  logic [DATA_TYPE-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr, r_rd;
  logic [PTR_W:0]       r_cnt;
  logic                 w_push_ok, w_pop_ok;
  assign o_full    = r_cnt == (PTR_W+1)'(FIFO_DEPTH);
  assign o_empty   = r_cnt == '0;
  assign o_count   = r_cnt;
  assign o_data    = r_mem[r_rd];
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_drop    = i_push && !w_push_ok;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop_ok) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (PTR_W+1)'(w_push_ok) - (PTR_W+1)'(w_pop_ok);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/vn_output_collector.sv
// vn_output_collector: per-lane VN FIFOs drained round-robin into one valid/ready stream.
// Define VN_COLLECT_STATS_EN to add the o_drain_cnt accepted-transfer counter.
module vn_output_collector
  import art_pkg::*;
#(
  parameter int DATA_TYPE  = ART_DATA_W,
  parameter int NUM_LANES  = 8,
  parameter int LANE_W     = $clog2(NUM_LANES),
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_LANES*DATA_TYPE-1:0] i_vn,
  input  logic [NUM_LANES-1:0]           i_vn_valid,
  output logic [DATA_TYPE-1:0]           o_data,
  output logic [LANE_W-1:0]              o_lane,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic                           o_overflow,
  output logic                           o_empty
`ifdef VN_COLLECT_STATS_EN
  ,output logic [31:0]                   o_drain_cnt
`endif
);
  logic [DATA_TYPE-1:0] w_fdata [NUM_LANES];
  logic [PTR_W:0]       w_cnt [NUM_LANES];
  logic [NUM_LANES-1:0] w_fempty, w_busy, w_pop, w_drop;
  logic [LANE_W-1:0]    r_rr, w_grant, w_idx;
  logic                 w_found, w_free;
  assign w_free  = !o_valid || i_ready;
  assign o_empty = !o_valid && !(|w_busy);
  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      vn_lane_fifo #(.DATA_TYPE(DATA_TYPE), .FIFO_DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (i_vn_valid[g]),
        .i_data  (i_vn[g*DATA_TYPE +: DATA_TYPE]),
        .i_pop   (w_pop[g]),
        .o_data  (w_fdata[g]),
        .o_full  (),
        .o_empty (w_fempty[g]),
        .o_count (w_cnt[g]),
        .o_drop  (w_drop[g])
      );
      assign w_busy[g] = |w_cnt[g];
      assign w_pop[g]  = w_free && w_found && (w_grant == LANE_W'(g));
    end
  endgenerate
  // Walk downward so the lane nearest rr_ptr+1 is the last, winning assignment.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = NUM_LANES; k >= 1; k--) begin
      w_idx = r_rr + LANE_W'(k);
      if (!w_fempty[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_lane     <= '0;
      o_overflow <= 1'b0;
      r_rr       <= '0;
    end else begin
      if (|w_drop) o_overflow <= 1'b1;
      if (w_free) o_valid <= w_found;
      if (w_free && w_found) begin
        o_data <= w_fdata[w_grant];
        o_lane <= w_grant;
        r_rr   <= w_grant;
      end
    end
  end
`ifdef VN_COLLECT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) o_drain_cnt <= '0;
    else if (o_valid && i_ready) o_drain_cnt <= o_drain_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_vn_output_collector.sv
// tb_vn_output_collector: directed stimulus with a queue scoreboard checked by a negedge monitor.
module tb_vn_output_collector;
  import art_pkg::*;
  localparam int DW = 32;
  localparam int NL = 8;
  typedef struct packed {logic [2:0] lane; logic [DW-1:0] data;} exp_t;
  logic            clk = 1'b0;
  logic            rst;
  logic [NL*DW-1:0] i_vn;
  logic [NL-1:0]   i_vn_valid;
  logic            i_ready;
  logic [DW-1:0]   o_data;
  logic [2:0]      o_lane;
  logic            o_valid, o_overflow, o_empty;
`ifdef VN_COLLECT_STATS_EN
  logic [31:0]     o_drain_cnt;
  int              accepted = 0;
`endif
  exp_t q[$];
  int checks = 0;
  int errors = 0;

  vn_output_collector dut (
    .clk        (clk),
    .rst        (rst),
    .i_vn       (i_vn),
    .i_vn_valid (i_vn_valid),
    .o_data     (o_data),
    .o_lane     (o_lane),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_overflow (o_overflow),
    .o_empty    (o_empty)
`ifdef VN_COLLECT_STATS_EN
    ,.o_drain_cnt(o_drain_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
`ifdef VN_COLLECT_STATS_EN
      accepted++;
`endif
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got lane %0d data %h expected nothing", o_lane, o_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_lane", 32'(o_lane), 32'(e.lane));
        chk("out_data", o_data, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int lane, input logic [DW-1:0] d, input bit expect_out);
    i_vn[lane*DW +: DW] = d;
    i_vn_valid[lane] = 1'b1;
    if (expect_out) q.push_back({3'(lane), d});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    q.delete();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_lane", 32'(o_lane), 32'd0);
    chk("rst_overflow", 32'(o_overflow), 32'd0);
    chk("rst_empty", 32'(o_empty), 32'd1);
`ifdef VN_COLLECT_STATS_EN
    accepted = 0;
    chk("rst_drain_cnt", o_drain_cnt, 32'd0);
`endif
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && (q.size() != 0 || !o_empty); i++) step();
    chk("drain_done", 32'(q.size() == 0 && o_empty), 32'd1);
`ifdef VN_COLLECT_STATS_EN
    chk("drain_cnt", o_drain_cnt, 32'(accepted));
`endif
  endtask

  initial begin
    rst = 1'b1;
    i_vn = '0;
    i_vn_valid = '0;
    i_ready = 1'b1;
    step();
    do_reset();
    // Single write: lane 3 (high half of switch 1), o_valid one edge after the write edge
    wr(3, 32'h3F800000, 1'b1);
    step();
    i_vn_valid = '0;
    chk("single_not_yet", 32'(o_valid), 32'd0);
    step();
    chk("single_valid", 32'(o_valid), 32'd1);
    chk("single_lane", 32'(o_lane), 32'd3);
    chk("single_data", o_data, 32'h3F800000);
    step();
    chk("single_empty", 32'(o_empty), 32'd1);
    // Round-robin from reset: search begins at lane 1, so 2, 5, 0
    do_reset();
    q.push_back({3'd2, 32'hBBBB_0002});
    q.push_back({3'd5, 32'hCCCC_0005});
    q.push_back({3'd0, 32'hAAAA_0000});
    wr(0, 32'hAAAA_0000, 1'b0);
    wr(2, 32'hBBBB_0002, 1'b0);
    wr(5, 32'hCCCC_0005, 1'b0);
    step();
    i_vn_valid = '0;
    step();
    chk("rr_first", 32'(o_lane), 32'd2);
    step();
    chk("rr_second", 32'(o_lane), 32'd5);
    step();
    chk("rr_third", 32'(o_lane), 32'd0);
    drain(10);
    // Backpressure: five lane-1 writes, output held stable while i_ready=0
    do_reset();
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr(1, 32'h1000 + 32'(i), 1'b1);
      step();
    end
    i_vn_valid = '0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", 32'(o_valid), 32'd1);
      chk("bp_lane", 32'(o_lane), 32'd1);
      chk("bp_data", o_data, 32'h1000);
      step();
    end
    chk("bp_no_overflow", 32'(o_overflow), 32'd0);
    i_ready = 1'b1;
    drain(20);
    // Overflow: register holds a lane-6 result, lane 7 gets 5 writes, the 5th is dropped
    do_reset();
    i_ready = 1'b0;
    wr(6, 32'h0000_6666, 1'b1);
    step();
    i_vn_valid = '0;
    for (int i = 0; i < 5; i++) begin
      wr(7, 32'h7000 + 32'(i), i < 4);
      step();
      if (i == 3) chk("ovf_not_yet", 32'(o_overflow), 32'd0);
    end
    i_vn_valid = '0;
    chk("ovf_set", 32'(o_overflow), 32'd1);
    i_ready = 1'b1;
    drain(20);
    chk("ovf_sticky", 32'(o_overflow), 32'd1);
    // Full push+pop on lane 0: no drop, count stays at depth
    do_reset();
    i_ready = 1'b0;
    wr(6, 32'h0000_006A, 1'b1);
    step();
    i_vn_valid = '0;
    for (int i = 0; i < 4; i++) begin
      wr(0, 32'hA0 + 32'(i), 1'b1);
      step();
    end
    i_vn_valid = '0;
    chk("full_count", 32'(dut.g_lane[0].u_fifo.o_count), 32'd4);
    i_ready = 1'b1;
    wr(0, 32'hA4, 1'b1);
    step();
    i_vn_valid = '0;
    chk("pushpop_count", 32'(dut.g_lane[0].u_fifo.o_count), 32'd4);
    chk("pushpop_no_ovf", 32'(o_overflow), 32'd0);
    drain(20);
    // Reset mid-drain with a write presented during the reset cycle
    do_reset();
    i_ready = 1'b0;
    wr(1, 32'hDEAD_0001, 1'b0);
    wr(2, 32'hDEAD_0002, 1'b0);
    wr(3, 32'hDEAD_0003, 1'b0);
    step();
    i_vn_valid = '0;
    step();
    chk("mid_valid_before", 32'(o_valid), 32'd1);
    i_vn_valid = '0;
    wr(4, 32'hDEAD_0004, 1'b0);
    do_reset();
    i_vn_valid = '0;
    i_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("mid_stays_empty", 32'(o_empty), 32'd1);
    chk("mid_stays_idle", 32'(o_valid), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end
endmodule
